uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (din / wr_en / tx_busy interface) between NUM_REQ requesters. Picks a winner round-robin, latches its byte, issues a one-cycle write strobe, and tracks the transmitter's busy flag through the frame. It then acknowledges the winner. Sits between client logic and the uart block, and owns that block's din and wr_en inputs.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 8, byte width on requester and UART side.
- START_TIMEOUT, 16, max cycles to wait for uart_tx_busy to rise after the strobe before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 asserts.
- req  in  NUM_REQ  per-requester request level; held until its ack.
- req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle pulse to the served requester.
- tx_err  out  1  one-cycle pulse coincident with ack when the start timeout fired.
- grant_id  out  clog2(NUM_REQ)  index of the current or last winner.
- arb_busy  out  1  high whenever state != IDLE.
- uart_din  out  DATA_W  byte to the UART, stable from the strobe until DONE.
- uart_wr_en  out  1  single-cycle write strobe to the UART.
- uart_tx_busy  in  1  transmitter busy flag from the UART.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, tx_err=0, grant_id=0, arb_busy=0, uart_din=0, uart_wr_en=0. State=IDLE, rr pointer=0 (requester 0 has top priority), timeout counter=0.
- State IDLE:
  - Acts when |req=1 and uart_tx_busy=0.
  - Winner = first set req bit searching from ptr upward, with wrap.
  - On that edge: uart_din <= req_data[winner], grant_id <= winner, uart_wr_en <= 1; next state WAIT_START.
  - If uart_tx_busy=1 in IDLE (foreign traffic), stay in IDLE and issue nothing.
- Latency: req sampled high at edge k gives uart_wr_en=1 during cycle k+1.
- State WAIT_START:
  - uart_wr_en <= 0 on the first edge; the strobe is exactly one cycle.
  - Counter increments each cycle.
  - uart_tx_busy=1 moves to WAIT_DONE.
  - Counter reaching START_TIMEOUT moves to DONE with err_flag set.
- State WAIT_DONE: stays until uart_tx_busy=0, then moves to DONE.
- State DONE (one cycle):
  - ack[grant_id]=1 and tx_err=err_flag during this cycle.
  - ptr <= (grant_id+1) mod NUM_REQ; counter and err_flag cleared.
  - Next state IDLE.
- Requester contract:
  - Hold req and data stable until ack is seen.
  - Drop req on the edge that samples ack=1, or the same requester is treated as a new request.
- Data is sampled only at grant. Changes to req_data afterwards are ignored.
- Deasserting req mid-transfer does not abort; ack still pulses.
- Simultaneous requests: exactly one grant per transfer. With all requesters high, service order is 0,1,2,...,NUM_REQ-1,0.
- ptr wraps from NUM_REQ-1 to 0. For non-power-of-two NUM_REQ, indices >= NUM_REQ are never produced.
- Reset mid-operation: immediate return to reset values; no ack and no tx_err for the aborted transfer.
- Throughput: at most one byte per (frame time + 3) cycles.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, WAIT_START, WAIT_DONE, DONE}.
  - Default constants NUM_REQ_DEF=4, DATA_W_DEF=8, START_TIMEOUT_DEF=16.
  - Function for index width, clog2 with minimum 1.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: winner index, valid.
  - Unit-testable alone; the FSM and counter stay in uart_tx_arbiter.

Test Plan:
- Single request:
  - Stimulus: req=4'b0100, req_data[2]=8'hA5, uart loopback.
  - Response: uart_wr_en one cycle with uart_din=8'hA5; ack=4'b0100 pulse after uart_tx_busy falls; loopback dout=8'hA5; tx_err=0.
- All four requesting from reset, data 8'h10,8'h21,8'h32,8'h43:
  - Grants in order 0,1,2,3; four acks, each one cycle.
  - dout sequence 10,21,32,43.
- Rotation:
  - Stimulus: after serving 2, assert req=4'b0101.
  - Response: requester 0 is granted before 2 (ptr=3 wraps to 0).
- Timeout:
  - Stimulus: UART stub holds uart_tx_busy=0.
  - Response: 16 cycles after the strobe, ack and tx_err pulse together; arbiter returns to IDLE and ptr advances.
- Reset mid-frame:
  - Stimulus: reset=0 for 2 cycles while in WAIT_DONE.
  - Response: all outputs at reset values; no ack; next request is served normally with correct data.
- Foreign busy:
  - Stimulus: uart_tx_busy forced high with req=4'b0001 pending.
  - Response: no uart_wr_en until busy drops; strobe follows one cycle later.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2,
        DONE       = 2'd3
    } arb_state_e;

    localparam int NUM_REQ_DEF       = 4;
    localparam int DATA_W_DEF        = 8;
    localparam int START_TIMEOUT_DEF = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;

    // Walk NUM_REQ positions from ptr, folding back at NUM_REQ so that
    // non-power-of-two sizes never produce an out-of-range index.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_i} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            if (!valid_o && req_i[sum[IDX_W-1:0]]) begin
                valid_o  = 1'b1;
                winner_o = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ requesters, round-robin.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | waiting for a request while the UART is not busy
// WAIT_START | strobe issued; waiting for uart_tx_busy to rise (timed)
// WAIT_DONE  | frame in flight; waiting for uart_tx_busy to fall
// DONE       | one cycle: ack (and tx_err on timeout), advance pointer
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ       = NUM_REQ_DEF,
    parameter int  DATA_W        = DATA_W_DEF,
    parameter int  START_TIMEOUT = START_TIMEOUT_DEF,
    localparam int IDX_W         = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      tx_err,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      arb_busy,
    output logic [DATA_W-1:0]         uart_din,
    output logic                      uart_wr_en,
    input  logic                      uart_tx_busy
);

    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_en_q, wr_en_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [IDX_W-1:0]  pick_id;
    logic              pick_valid;
    logic [DATA_W-1:0] req_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_byte[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (pick_id),
        .valid_o  (pick_valid)
    );

    // Next-state and registered-output decisions; ack/err/strobe are pulses.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        wr_en_d = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid && !uart_tx_busy) begin
                    din_d   = req_byte[pick_id];
                    grant_d = pick_id;
                    wr_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                cnt_d = cnt_q + 1'b1;
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_d == CNT_W'(START_TIMEOUT)) begin
                    state_d = DONE;
                    ack_d   = NUM_REQ'(1'b1) << grant_q;
                    err_d   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = DONE;
                    ack_d   = NUM_REQ'(1'b1) << grant_q;
                end
            end
            DONE: begin
                ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any transfer silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            wr_en_q <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            wr_en_q <= wr_en_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign tx_err     = err_q;
    assign grant_id   = grant_q;
    assign arb_busy   = busy_q;
    assign uart_din   = din_q;
    assign uart_wr_en = wr_en_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-timeline model plus directed cases.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  ack;
    logic          tx_err;
    logic [1:0]    grant_id;
    logic          arb_busy;
    logic [DW-1:0] uart_din;
    logic          uart_wr_en;
    logic          uart_tx_busy;
    logic          stub_busy;
    logic          foreign_busy;

    assign uart_tx_busy = stub_busy | foreign_busy;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .DATA_W        (DW),
        .START_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .tx_err       (tx_err),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int last_wr_cyc  = 0;
    int last_ack_cyc = 0;
    int n_acks  = 0;
    int ack_log[$];
    int cap_log[$];

    // UART stub: 0 random timing, 1 fast frame, 2 never busy, 3 long frame
    int stub_mode  = 1;
    int stub_lat   = -1;
    int stub_frame = 0;
    int stub_frame_cfg = 10;

    // Behavioural model: a transfer is an open window from strobe to ack.
    bit m_open, m_done, m_rose;
    int m_since, m_ptr;
    int e_gid, e_din, e_ack, e_err, e_wr, e_busy;

    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_open = 0; m_done = 0; m_rose = 0; m_since = 0; m_ptr = 0;
        e_gid = 0; e_din = 0; e_ack = 0; e_err = 0; e_wr = 0; e_busy = 0;
    endtask

    task automatic finish_xfer(input int err);
        e_ack  = 1 << e_gid;
        e_err  = err;
        m_done = 1;
    endtask

    task automatic model_step();
        e_wr = 0; e_ack = 0; e_err = 0;
        if (m_done) begin
            m_open = 0;
            m_done = 0;
            m_ptr  = (e_gid + 1) % N;
        end else if (m_open) begin
            m_since++;
            if (m_rose) begin
                if (!uart_tx_busy) finish_xfer(0);
            end else if (uart_tx_busy) begin
                m_rose = 1;
            end else if (m_since == TO) begin
                finish_xfer(1);
            end
        end else if (req != '0 && !uart_tx_busy) begin
            e_gid   = rr_winner(req, m_ptr);
            e_din   = int'(req_data[e_gid*DW +: DW]);
            e_wr    = 1;
            m_open  = 1;
            m_rose  = 0;
            m_since = 0;
        end
        e_busy = int'(m_open);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("ack",      int'(ack),        e_ack);
        check("tx_err",   int'(tx_err),     e_err);
        check("grant_id", int'(grant_id),   e_gid);
        check("arb_busy", int'(arb_busy),   e_busy);
        check("uart_din", int'(uart_din),   e_din);
        check("wr_en",    int'(uart_wr_en), e_wr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},      int'(ack),        0);
        check({tag, "_tx_err"},   int'(tx_err),     0);
        check({tag, "_grant_id"}, int'(grant_id),   0);
        check({tag, "_arb_busy"}, int'(arb_busy),   0);
        check({tag, "_din"},      int'(uart_din),   0);
        check({tag, "_wr_en"},    int'(uart_wr_en), 0);
    endtask

    task automatic stub_step();
        if (!reset) begin
            stub_lat = -1; stub_frame = 0; stub_busy = 1'b0;
        end else begin
            if (uart_wr_en && stub_mode != 2) begin
                case (stub_mode)
                    0: begin
                        stub_lat = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 2));
                        stub_frame_cfg = int'($urandom_range(1, 10));
                    end
                    3:       begin stub_lat = 0; stub_frame_cfg = 40; end
                    default: begin stub_lat = 0; stub_frame_cfg = 10; end
                endcase
            end
            if (stub_lat == 0) begin
                stub_busy  = 1'b1;
                stub_frame = stub_frame_cfg;
                stub_lat   = -1;
            end else if (stub_lat > 0) begin
                stub_lat--;
            end else if (stub_frame > 0) begin
                stub_frame--;
                if (stub_frame == 0) stub_busy = 1'b0;
            end
        end
    endtask

    // One cycle: sample/compare at the falling edge, then react as UART and requesters.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (reset) begin
            check_outputs();
            if (ack != '0) begin
                ack_log.push_back(onehot_idx(ack));
                n_acks++;
                last_ack_cyc = cyc;
            end
            if (uart_wr_en) begin
                cap_log.push_back(int'(uart_din));
                last_wr_cyc = cyc;
            end
        end
        stub_step();
        if (reset) req = req & ~ack;
    endtask

    task automatic set_byte(input int i, input logic [DW-1:0] b);
        req_data[i*DW +: DW] = b;
    endtask

    task automatic wait_wr(input string name);
        int k = 0;
        do begin tick(); k++; end while (!uart_wr_en && k < 200);
        check({name, "_strobe_seen"}, int'(uart_wr_en), 1);
    endtask

    task automatic wait_ack(input string name);
        int k = 0;
        do begin tick(); k++; end while (ack == '0 && k < 300);
        check({name, "_ack_seen"}, int'(ack != '0), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; foreign_busy = 1'b0;
        tick();
        check_reset_values("rst");
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int w;
        reset = 1'b0; req = '0; req_data = '0; foreign_busy = 1'b0; stub_busy = 1'b0;
        tick();
        check_reset_values("por");
        tick();
        reset = 1'b1;
        tick();

        // single request
        stub_mode = 1;
        set_byte(2, 8'hA5);
        req = 4'b0100;
        wait_wr("t1");
        check("t1_din", int'(uart_din), 'hA5);
        check("t1_grant", int'(grant_id), 2);
        wait_ack("t1");
        check("t1_ack", int'(ack), 'b0100);
        check("t1_err", int'(tx_err), 0);
        check("t1_loopback", cap_log.size() > 0 ? cap_log[$] : -1, 'hA5);

        // all four requesting from reset
        do_reset();
        ack_log.delete(); cap_log.delete();
        set_byte(0, 8'h10); set_byte(1, 8'h21); set_byte(2, 8'h32); set_byte(3, 8'h43);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) wait_ack("t2");
        check("t2_acks", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) check("t2_order", ack_log[i], i);
        for (int i = 0; i < 4 && i < cap_log.size(); i++) check("t2_dout", cap_log[i], 'h10 + 'h11 * i);

        // rotation: after serving 2, pointer wraps past 3 to 0
        do_reset();
        set_byte(2, 8'h55);
        req = 4'b0100;
        wait_ack("t3a");
        set_byte(0, 8'h11); set_byte(2, 8'h22);
        req = 4'b0101;
        wait_ack("t3b");
        check("t3_first", int'(ack), 'b0001);
        wait_ack("t3c");
        check("t3_second", int'(ack), 'b0100);

        // start timeout with a dead UART
        stub_mode = 2;
        set_byte(1, 8'h66);
        req = 4'b0010;
        wait_wr("t4");
        w = last_wr_cyc;
        wait_ack("t4");
        check("t4_latency", last_ack_cyc - w, 16);
        check("t4_ack", int'(ack), 'b0010);
        check("t4_err", int'(tx_err), 1);
        stub_mode = 1;
        req = 4'b0101;
        wait_ack("t4b");
        check("t4_ptr_adv", int'(ack), 'b0100);
        wait_ack("t4c");
        check("t4_tail", int'(ack), 'b0001);

        // reset while a frame is in flight
        stub_mode = 3;
        set_byte(1, 8'h77);
        req = 4'b0010;
        wait_wr("t5");
        repeat (5) tick();
        check("t5_in_frame", int'(arb_busy), 1);
        reset = 1'b0;
        req = '0;
        tick();
        check_reset_values("t5a");
        tick();
        check_reset_values("t5b");
        reset = 1'b1;
        stub_mode = 1;
        set_byte(1, 8'h5C);
        req = 4'b0010;
        wait_wr("t5c");
        check("t5_din", int'(uart_din), 'h5C);
        check("t5_grant", int'(grant_id), 1);
        wait_ack("t5c");
        check("t5_ack", int'(ack), 'b0010);
        check("t5_err", int'(tx_err), 0);

        // foreign traffic holds the arbiter off
        foreign_busy = 1'b1;
        set_byte(0, 8'h3C);
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_strobe", int'(uart_wr_en), 0);
        end
        foreign_busy = 1'b0;
        tick();
        check("t6_strobe_next", int'(uart_wr_en), 1);
        check("t6_din", int'(uart_din), 'h3C);
        wait_ack("t6");

        // randomized traffic against the model
        stub_mode = 0;
        n_acks = 0;
        begin
            int f_left = 0;
            for (int c = 0; c < 3000; c++) begin
                tick();
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && $urandom_range(0, 7) == 0) begin
                        req[i] = 1'b1;
                        set_byte(i, DW'($urandom));
                    end
                end
                if (m_open && !m_done && $urandom_range(0, 3) == 0) set_byte(e_gid, DW'($urandom));
                if (m_open && !m_done && $urandom_range(0, 40) == 0) req[e_gid] = 1'b0;
                if (f_left > 0) begin
                    f_left--;
                    if (f_left == 0) foreign_busy = 1'b0;
                end else if (!stub_busy && $urandom_range(0, 60) == 0) begin
                    f_left = int'($urandom_range(1, 8));
                    foreign_busy = 1'b1;
                end
            end
            foreign_busy = 1'b0;
        end
        check("rand_traffic", int'(n_acks > 20), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
